// File: rtl/det_matrix_loader.sv
// det_matrix_loader: buffers an n x n matrix for the determinant engine and holds its result.
// Optional feature macro: DET_LOADER_ERR_EN (reject bad dimension words and raise err).
module det_matrix_loader #(
  parameter int MAX     = 20,
  parameter int DIM_MAX = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAX-1:0]   in_data,
  output logic             det_reset,
  input  logic [MAX-1:0]   i,
  input  logic [MAX-1:0]   j,
  input  logic             read,
  output logic [MAX-1:0]   read_data,
  input  logic [2*MAX-1:0] write_data,
  input  logic             finish,
  output logic [2*MAX-1:0] result,
  output logic             result_valid,
  input  logic             result_ack
`ifdef DET_LOADER_ERR_EN
  ,
  output logic             err
`endif
);
  localparam int NW    = $clog2(DIM_MAX + 1);
  localparam int DEPTH = DIM_MAX * DIM_MAX;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_LOAD_N,
    S_LOAD_ELEM,
    S_HDR,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [NW-1:0]    row_q, row_d;
  logic [NW-1:0]    col_q, col_d;
  logic [2*MAX-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic [MAX-1:0]   mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             xfer, row_last, col_last, i_in, j_in;
  logic [NW-1:0]    dim_word;
  logic             dim_ok;
  logic             unused_read;
`ifdef DET_LOADER_ERR_EN
  logic             err_q, err_d;
`endif

  assign unused_read = read;

  assign in_ready  = (state_q == S_LOAD_N) || (state_q == S_LOAD_ELEM);
  assign det_reset = !((state_q == S_HDR) || (state_q == S_RUN));
  assign xfer      = in_valid && in_ready;
  assign row_last  = (row_q == n_q - NW'(1));
  assign col_last  = (col_q == n_q - NW'(1));
  assign wr_idx    = AW'(row_q) * AW'(DIM_MAX) + AW'(col_q);
  assign i_in      = (i < MAX'(n_q));
  assign j_in      = (j < MAX'(n_q));
  // Only meaningful when i_in && j_in, so the truncated low bits suffice.
  assign rd_idx    = AW'(i[NW-1:0]) * AW'(DIM_MAX) + AW'(j[NW-1:0]);

`ifdef DET_LOADER_ERR_EN
  assign dim_ok   = (in_data != '0) && (in_data <= MAX'(DIM_MAX));
  assign dim_word = NW'(in_data);
`else
  assign dim_ok   = 1'b1;
  always_comb begin
    if (in_data == '0)
      dim_word = NW'(1);
    else if (in_data > MAX'(DIM_MAX))
      dim_word = NW'(DIM_MAX);
    else
      dim_word = NW'(in_data);
  end
`endif

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    row_d          = row_q;
    col_d          = col_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    mem_we         = 1'b0;
`ifdef DET_LOADER_ERR_EN
    err_d          = err_q;
`endif
    case (state_q)
      S_LOAD_N: begin
        if (xfer) begin
          row_d = '0;
          col_d = '0;
`ifdef DET_LOADER_ERR_EN
          err_d = !dim_ok;
`endif
          if (dim_ok) begin
            n_d     = dim_word;
            state_d = S_LOAD_ELEM;
          end
        end
      end
      S_LOAD_ELEM: begin
        if (xfer) begin
          mem_we = 1'b1;
          if (col_last) begin
            col_d = '0;
            if (row_last)
              state_d = S_HDR;
            else
              row_d = row_q + NW'(1);
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      S_HDR: state_d = S_RUN;
      S_RUN: begin
        if (finish) begin
          result_d       = write_data;
          result_valid_d = 1'b1;
          state_d        = S_DONE;
        end
      end
      S_DONE: begin
        if (result_ack) begin
          result_valid_d = 1'b0;
          state_d        = S_LOAD_N;
        end
      end
      default: state_d = S_LOAD_N;
    endcase
  end

  always_comb begin
    read_data = '0;
    if (state_q == S_HDR)
      read_data = MAX'(n_q);
    else if (state_q == S_RUN && i_in && j_in)
      read_data = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_LOAD_N;
      n_q            <= '0;
      row_q          <= '0;
      col_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      row_q          <= row_d;
      col_q          <= col_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Matrix storage carries no reset; stale entries are never read outside the n x n window.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[wr_idx] <= in_data;
  end

`ifdef DET_LOADER_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end
  assign err = err_q;
`endif

  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_det_matrix_loader.sv
// Directed bench for det_matrix_loader: the bench plays upstream feeder, engine and result consumer.
module tb_det_matrix_loader;
  localparam int MAX     = 20;
  localparam int DIM_MAX = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [MAX-1:0]   in_data = '0;
  logic [MAX-1:0]   i = '0;
  logic [MAX-1:0]   j = '0;
  logic             read = 1'b0;
  logic [2*MAX-1:0] write_data = '0;
  logic             finish = 1'b0;
  logic             result_ack = 1'b0;
  logic             in_ready, det_reset, result_valid;
  logic [MAX-1:0]   read_data;
  logic [2*MAX-1:0] result;
`ifdef DET_LOADER_ERR_EN
  logic             err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int words[$];

  always #5 clk = ~clk;

  det_matrix_loader #(.MAX(MAX), .DIM_MAX(DIM_MAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .det_reset(det_reset), .i(i), .j(j), .read(read), .read_data(read_data),
    .write_data(write_data), .finish(finish), .result(result), .result_valid(result_valid),
    .result_ack(result_ack)
`ifdef DET_LOADER_ERR_EN
    , .err(err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input int w);
    int   cyc = 0;
    logic rdy = 1'b0;
    in_valid = 1'b1;
    in_data  = MAX'(w);
    while (!rdy && cyc < 50) begin
      rdy = in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("send_word_accepted", 64'(rdy), 64'(1));
  endtask

  // Streams words[], checks HDR/RUN reads, plays the engine, then acks after `hold` DONE cycles.
  task automatic run_job(input string name, input int n_eff, input int det, input int hold);
    int               k = 0;
    int               cyc = 0;
    logic             rdy;
    logic [MAX-1:0]   e;
    logic [2*MAX-1:0] exp_res;
    exp_res  = {{(2*MAX-32){det[31]}}, det};
    in_valid = 1'b1;
    while (k < words.size() && cyc < 200) begin
      in_data = MAX'(words[k]);
      rdy     = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy) k++;
    end
    in_valid = 1'b0;
    check({name, "_xfer_cycles"}, 64'(cyc), 64'(words.size()));
    i = MAX'(5); j = MAX'(5);
    #1;
    check({name, "_hdr_in_ready"}, 64'(in_ready), 64'(0));
    check({name, "_hdr_det_reset"}, 64'(det_reset), 64'(0));
    check({name, "_hdr_n"}, 64'(read_data), 64'(n_eff));
    @(posedge clk); #1;
    check({name, "_run_det_reset"}, 64'(det_reset), 64'(0));
    read = 1'b1;
    for (int r = 0; r <= DIM_MAX; r++) begin
      for (int c = 0; c <= DIM_MAX; c++) begin
        i = MAX'(r); j = MAX'(c);
        #1;
        e = (r < n_eff && c < n_eff) ? MAX'(words[1 + r*n_eff + c]) : '0;
        check($sformatf("%s_rd_%0d_%0d", name, r, c), 64'(read_data), 64'(e));
      end
    end
    i = '1; j = '0;
    #1;
    check({name, "_rd_far_row"}, 64'(read_data), 64'(0));
    read = 1'b0;
    i = '0; j = '0;
    @(negedge clk);
    finish     = 1'b1;
    write_data = exp_res;
    @(posedge clk); #1;
    finish     = 1'b0;
    write_data = '0;
    check({name, "_done_valid"}, 64'(result_valid), 64'(1));
    check({name, "_done_result"}, 64'(result), 64'(exp_res));
    check({name, "_done_det_reset"}, 64'(det_reset), 64'(1));
    check({name, "_done_read_data"}, 64'(read_data), 64'(0));
    check({name, "_done_in_ready"}, 64'(in_ready), 64'(0));
    in_valid = (hold > 0);
    in_data  = MAX'(2);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({name, "_hold_in_ready"}, 64'(in_ready), 64'(0));
      check({name, "_hold_valid"}, 64'(result_valid), 64'(1));
      check({name, "_hold_result"}, 64'(result), 64'(exp_res));
    end
    in_valid   = 1'b0;
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    check({name, "_ack_valid"}, 64'(result_valid), 64'(0));
    check({name, "_ack_in_ready"}, 64'(in_ready), 64'(1));
    check({name, "_ack_result_kept"}, 64'(result), 64'(exp_res));
    $display("job %s: n=%0d det=%0d result=%h", name, n_eff, det, result);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_det_reset", 64'(det_reset), 64'(1));
    check("rst_read_data", 64'(read_data), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_result_valid", 64'(result_valid), 64'(0));
`ifdef DET_LOADER_ERR_EN
    check("rst_err", 64'(err), 64'(0));
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    words = '{2, 3, 4, 1, 2};
    run_job("t1_2x2", 2, 2, 0);

    words = '{3, 1, 2, 3, 0, 1, 4, 5, 6, 0};
    run_job("t2_3x3", 3, 1, 0);

    words = '{2, -2, 0, 0, 5};
    run_job("t3_signed", 2, -10, 0);

`ifdef DET_LOADER_ERR_EN
    send_word(7);
    check("t4_err_set", 64'(err), 64'(1));
    check("t4_stay_load_n", 64'(in_ready), 64'(1));
    check("t4_det_reset", 64'(det_reset), 64'(1));
    send_word(0);
    check("t4_err_zero", 64'(err), 64'(1));
    words = '{2, 1, 2, 3, 4};
    run_job("t4_after_err", 2, -2, 0);
    check("t4_err_cleared", 64'(err), 64'(0));
`else
    words = '{7, 1, 2, 3, 4, 5, 6, 7, 8, 10};
    run_job("t4_clamp_hi", 3, -3, 0);
    words = '{0, 7};
    run_job("t4_clamp_lo", 1, 7, 0);
`endif

    send_word(3);
    send_word(1);
    send_word(2);
    send_word(3);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_in_ready", 64'(in_ready), 64'(1));
    check("t5_rst_det_reset", 64'(det_reset), 64'(1));
    check("t5_rst_valid", 64'(result_valid), 64'(0));
    check("t5_rst_result", 64'(result), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    words = '{2, 5, 6, 7, 8};
    run_job("t5_after_rst", 2, -2, 0);

    words = '{2, 1, 0, 0, 1};
    run_job("t6_hold", 2, 1, 10);

    @(negedge clk);
    finish     = 1'b1;
    write_data = 40'h12345;
    @(posedge clk); #1;
    finish     = 1'b0;
    write_data = '0;
    check("t7_finish_ignored_valid", 64'(result_valid), 64'(0));
    check("t7_finish_ignored_result", 64'(result), 64'(1));
    check("t7_still_load_n", 64'(in_ready), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/det_matrix_loader.md
# det_matrix_loader

Upstream feeder for the determinant engine. Accepts a matrix as a valid/ready word stream (dimension word, then elements row-major) and stores it in an internal register array. Holds the engine in reset until the matrix is complete, then serves its `i`/`j` reads combinationally. Captures the engine's `write_data` when `finish` rises and holds it for a downstream consumer until acknowledged.

## Interface
- `MAX`, 20: element width in bits; also the width of the `i`/`j` address buses.
- `DIM_MAX`, 3: largest supported dimension n; storage is `DIM_MAX*DIM_MAX` words.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  MAX  upstream word: dimension n first, then n*n signed elements row-major.
- `det_reset`  out  1  active-high synchronous reset to the engine.
- `i`, `j`  in  MAX  engine row/column address.
- `read`  in  1  engine read strobe; informational only, does not gate `read_data`.
- `read_data`  out  MAX  word returned to the engine.
- `write_data`  in  2*MAX  engine result, signed.
- `finish`  in  1  engine completion flag.
- `result`  out  2*MAX  captured determinant, signed.
- `result_valid`  out  1  `result` holds an unacknowledged value.
- `result_ack`  in  1  downstream consumed `result`.
- `err`  out  1  sticky invalid-dimension flag; present only with `DET_LOADER_ERR_EN`.

## Operation
- FSM states: LOAD_N, LOAD_ELEM, HDR, RUN, DONE.
- A transfer occurs on a rising edge with `in_valid && in_ready`.
- `in_ready` = (state is LOAD_N or LOAD_ELEM). It is a pure state decode.
- **LOAD_N**
  - On transfer, latch n = `in_data` and clear the element counter.
  - If n is valid, go to LOAD_ELEM.
- **LOAD_ELEM**
  - Each transfer writes `mem[cnt/n][cnt%n]`, then increments cnt.
  - The transfer with cnt = n*n-1 moves the FSM to HDR.
- **HDR** (exactly 1 cycle)
  - `det_reset` = 0.
  - `read_data` = n, zero-extended, regardless of `i`/`j`.
  - Next state: RUN.
- **RUN**
  - `det_reset` = 0.
  - `read_data` = `mem[i][j]` when both `i` and `j` are < n; otherwise 0.
  - The first rising edge sampling `finish`=1 latches `result <= write_data`, sets `result_valid`, and moves to DONE.
- **DONE**
  - `det_reset` = 1; `read_data` = 0.
  - `result_ack`=1 clears `result_valid` and returns to LOAD_N.
  - `result` keeps its value until the next capture.
- `det_reset` = 1 in LOAD_N, LOAD_ELEM and DONE.
- `read_data` = 0 in LOAD_N, LOAD_ELEM and DONE.
- Elements are stored verbatim, MAX bits signed. `result` is not sign-extended; it is exactly `write_data`.

## Timing
- Reset values, applied asynchronously while `reset`=0:
  - state LOAD_N, so `in_ready`=1.
  - `det_reset`=1, `read_data`=0, `result`=0, `result_valid`=0, `err`=0, n=0, cnt=0.
  - Memory contents are don't-care.
- Reset asserted mid-load or mid-run aborts the job immediately; `det_reset` goes high asynchronously.
- Load latency: 1+n*n transfers; back-to-back transfers are allowed every cycle.
- `in_ready` falls in the cycle after the last element transfer. `in_valid` while `in_ready`=0 is ignored.
- `det_reset` falls in the HDR cycle. The engine samples n at the edge ending HDR.
- `result_valid` rises 1 cycle after the `finish` sample and stays high until the edge sampling `result_ack`=1.
- `in_ready` returns 1 in that same next cycle.
- `result_ack` outside DONE is ignored.
- `finish` outside RUN is ignored.

## Configuration
- `DET_LOADER_ERR_EN` defined:
  - A dimension word with n=0 or n>`DIM_MAX` is discarded; the FSM stays in LOAD_N and `err` sets.
  - `err` clears on the next accepted valid dimension word or on reset.
- Not defined:
  - The `err` port is absent.
  - n=0 is clamped to 1; n>`DIM_MAX` is clamped to `DIM_MAX`.
  - The FSM always proceeds to LOAD_ELEM.

## Test plan
- Reset release, then stream 2,3,4,1,2 with `in_valid` held high -> 5 consecutive transfers; HDR shows `read_data`=2; `result`=2; `result_valid` high until ack.
- Stream 3,1,2,3,0,1,4,5,6,0 -> `result`=1; `det_reset` is low only during HDR/RUN.
- Stream 2,-2,0,0,5 -> `result`=-10 (all 2*MAX bits set except the low pattern 0x...FFF6); signed storage verified.
- Dimension word 7 then 2,... -> with `DET_LOADER_ERR_EN`: 7 dropped, `err`=1, then cleared by the 2 and the job completes. Without the macro: n clamped to 3.
- `reset` pulsed low after 3 element transfers -> `in_ready`=1, `det_reset`=1, `result_valid`=0 immediately; a fresh 2x2 job then completes correctly.
- Hold `result_ack`=0 for 10 cycles in DONE with `in_valid`=1 -> no transfers, `result` stable. Ack -> `in_ready`=1 on the next cycle.
